// File: rtl/alu_issue_ctrl_pkg.sv
// alu_ctrl_pkg: alufn codes, code classification helpers and issue FSM states
package alu_ctrl_pkg;

    localparam logic [5:0] FN_ADD    = 6'b100000;
    localparam logic [5:0] FN_ADDC   = 6'b110000;
    localparam logic [5:0] FN_AND    = 6'b101000;
    localparam logic [5:0] FN_ANDC   = 6'b111000;
    localparam logic [5:0] FN_CMPEQ  = 6'b100100;
    localparam logic [5:0] FN_CMPEQC = 6'b110100;
    localparam logic [5:0] FN_CMPLE  = 6'b100110;
    localparam logic [5:0] FN_CMPLEC = 6'b110110;
    localparam logic [5:0] FN_CMPLT  = 6'b100101;
    localparam logic [5:0] FN_CMPLTC = 6'b110101;
    localparam logic [5:0] FN_LD     = 6'b011000;
    localparam logic [5:0] FN_LDR    = 6'b011111;
    localparam logic [5:0] FN_MUL    = 6'b100010;
    localparam logic [5:0] FN_MULC   = 6'b110010;
    localparam logic [5:0] FN_OR     = 6'b101001;
    localparam logic [5:0] FN_ORC    = 6'b111001;
    localparam logic [5:0] FN_SHL    = 6'b101100;
    localparam logic [5:0] FN_SHLC   = 6'b111100;
    localparam logic [5:0] FN_SHR    = 6'b101101;
    localparam logic [5:0] FN_SHRC   = 6'b111101;
    localparam logic [5:0] FN_SRA    = 6'b101110;
    localparam logic [5:0] FN_ST     = 6'b011001;
    localparam logic [5:0] FN_SUB    = 6'b100001;
    localparam logic [5:0] FN_SUBC   = 6'b110001;
    localparam logic [5:0] FN_XOR    = 6'b101010;
    localparam logic [5:0] FN_XORC   = 6'b111010;
    localparam logic [5:0] FN_JMP    = 6'b011011;
    localparam logic [5:0] FN_BEQ    = 6'b011101;
    localparam logic [5:0] FN_BNE    = 6'b011110;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    function automatic logic is_mul_fn(input logic [5:0] fn);
        return fn inside {FN_MUL, FN_MULC};
    endfunction

    function automatic logic is_legal_fn(input logic [5:0] fn);
        return fn inside {FN_ADD, FN_ADDC, FN_AND, FN_ANDC, FN_CMPEQ, FN_CMPEQC,
                          FN_CMPLE, FN_CMPLEC, FN_CMPLT, FN_CMPLTC, FN_LD, FN_LDR,
                          FN_MUL, FN_MULC, FN_OR, FN_ORC, FN_SHL, FN_SHLC, FN_SHR,
                          FN_SHRC, FN_SRA, FN_ST, FN_SUB, FN_SUBC, FN_XOR, FN_XORC,
                          FN_JMP, FN_BEQ, FN_BNE};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: requester, ALU and response channels of the ALU issue controller
interface alu_issue_ctrl_if #(parameter int DW = 32);
    logic          req0_valid;
    logic          req0_ready;
    logic [5:0]    req0_fn;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic          req1_valid;
    logic          req1_ready;
    logic [5:0]    req1_fn;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [5:0]    alu_fn;
    logic [DW-1:0] alu_y;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;

    modport slave (
        input  req0_valid, req0_fn, req0_a, req0_b,
        input  req1_valid, req1_fn, req1_a, req1_b,
        input  alu_y, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_fn,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_fn, req0_a, req0_b,
        output req1_valid, req1_fn, req1_a, req1_b,
        output alu_y, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_fn,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/alu_issue_ctrl_rr_arb2.sv
// alu_rr_arb2: two-way round-robin grant; pointer moves to the loser on each accept
module alu_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic v0,
    input  logic v1,
    input  logic en,
    output logic g0,
    output logic g1
);
    logic ptr;

    assign g0 = v0 & (~v1 | ~ptr);
    assign g1 = v1 & (~v0 | ptr);

    // After a grant the other requester gets priority on the next contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= 1'b0;
        else if (en) ptr <= g0;
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: shares one combinational ALU between two requesters (optional ALU_ILLEGAL_FN_CHECK_EN)
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 3,
    parameter int DW = 32
) (
    input logic clk,
    input logic rst_n,
    alu_issue_ctrl_if.slave bus
);
    localparam int CW = $clog2(MUL_CYCLES + 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          id_q, g0, g1, idle, accept, ill;
    logic [5:0]    fn_in;
    logic [DW-1:0] a_in, b_in;

    alu_rr_arb2 u_arb (
        .clk(clk), .rst_n(rst_n), .v0(bus.req0_valid), .v1(bus.req1_valid),
        .en(accept), .g0(g0), .g1(g1)
    );

    assign idle   = state == IDLE;
    assign accept = idle & (bus.req0_valid | bus.req1_valid);
    assign fn_in  = g1 ? bus.req1_fn : bus.req0_fn;
    assign a_in   = g1 ? bus.req1_a : bus.req0_a;
    assign b_in   = g1 ? bus.req1_b : bus.req0_b;
    // Readiness is forced low while reset is held so nothing looks accepted.
    assign bus.req0_ready = rst_n & idle & g0;
    assign bus.req1_ready = rst_n & idle & g1;
    assign bus.busy = ~idle;

`ifdef ALU_ILLEGAL_FN_CHECK_EN
    assign ill = ~is_legal_fn(fn_in);
`else
    assign ill = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // Next state: illegal codes skip EXEC and answer directly.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = accept ? (ill ? RESP : EXEC) : IDLE;
            EXEC:    state_nx = cnt == '0 ? RESP : EXEC;
            RESP:    state_nx = bus.rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Operand issue, multiply countdown and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_fn    <= FN_ADD;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            id_q          <= 1'b0;
            cnt           <= '0;
        end else begin
            if (accept) begin
                id_q <= g1;
                cnt  <= is_mul_fn(fn_in) ? CW'(MUL_CYCLES - 1) : '0;
                if (ill) begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_id    <= g1;
                    bus.rsp_data  <= '0;
                    bus.rsp_err   <= 1'b1;
                end else begin
                    bus.alu_fn <= fn_in;
                    bus.alu_a  <= a_in;
                    bus.alu_b  <= b_in;
                end
            end
            if (state == EXEC && cnt == '0) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_id    <= id_q;
                bus.rsp_data  <= bus.alu_y;
                bus.rsp_err   <= 1'b0;
            end else if (state == EXEC) begin
                cnt <= cnt - 1'b1;
            end
            if (state == RESP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl against a latency-level model
module tb_alu_issue_ctrl;
    localparam int MC = 3;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DW(DW)) bus();
    alu_issue_ctrl #(.MUL_CYCLES(MC), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference ALU: a few real operations, everything else a fixed mix.
    function automatic logic [DW-1:0] alu_ref(input logic [5:0] fn, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (fn)
            6'b100000, 6'b110000: return a + b;
            6'b100001, 6'b110001: return a - b;
            6'b101000, 6'b111000: return a & b;
            6'b101001, 6'b111001: return a | b;
            6'b101010, 6'b111010: return a ^ b;
            6'b100010, 6'b110010: return a * b;
            default:              return a ^ ~b;
        endcase
    endfunction

    always_comb bus.alu_y = alu_ref(bus.alu_fn, bus.alu_a, bus.alu_b);

`ifdef ALU_ILLEGAL_FN_CHECK_EN
    logic [5:0] legal_q[$] = '{6'b100000, 6'b110000, 6'b101000, 6'b111000, 6'b100100, 6'b110100,
        6'b100110, 6'b110110, 6'b100101, 6'b110101, 6'b011000, 6'b011111, 6'b100010, 6'b110010,
        6'b101001, 6'b111001, 6'b101100, 6'b111100, 6'b101101, 6'b111101, 6'b101110, 6'b011001,
        6'b100001, 6'b110001, 6'b101010, 6'b111010, 6'b011011, 6'b011101, 6'b011110};
    function automatic bit tb_legal(input logic [5:0] fn);
        foreach (legal_q[i]) if (legal_q[i] == fn) return 1'b1;
        return 1'b0;
    endfunction
`endif

    // Model: an op in flight counts down its latency; a response waits for rsp_ready.
    bit m_fl, m_rsp, m_id, m_err, m_pid, m_ptr, m_acc0, m_acc1;
    int m_wait;
    logic [DW-1:0] m_data, m_pend, m_a, m_b;
    logic [5:0] m_fn;

    task automatic m_reset();
        m_fl = 0; m_rsp = 0; m_id = 0; m_err = 0; m_pid = 0; m_ptr = 0;
        m_acc0 = 0; m_acc1 = 0; m_wait = 0;
        m_data = '0; m_pend = '0; m_a = '0; m_b = '0; m_fn = 6'b100000;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int winner();
        if (bus.req0_valid && bus.req1_valid) return int'(m_ptr);
        return bus.req1_valid ? 1 : 0;
    endfunction

    task automatic compare();
        bit idle = !m_fl && !m_rsp;
        int w = winner();
        chk("req0_ready", 64'(bus.req0_ready), 64'(idle && bus.req0_valid && w == 0));
        chk("req1_ready", 64'(bus.req1_ready), 64'(idle && bus.req1_valid && w == 1));
        chk("busy", 64'(bus.busy), 64'(!idle));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp));
        chk("rsp_data", 64'(bus.rsp_data), 64'(m_data));
        chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
        chk("rsp_err", 64'(bus.rsp_err), 64'(m_err));
        chk("alu_a", 64'(bus.alu_a), 64'(m_a));
        chk("alu_b", 64'(bus.alu_b), 64'(m_b));
        chk("alu_fn", 64'(bus.alu_fn), 64'(m_fn));
    endtask

    task automatic step();
        bit idle = !m_fl && !m_rsp;
        int w = winner();
        logic [5:0] fn = w == 1 ? bus.req1_fn : bus.req0_fn;
        logic [DW-1:0] a = w == 1 ? bus.req1_a : bus.req0_a;
        logic [DW-1:0] b = w == 1 ? bus.req1_b : bus.req0_b;
        bit bad = 1'b0;
        m_acc0 = 0;
        m_acc1 = 0;
        if (m_rsp && bus.rsp_ready) m_rsp = 0;
        if (m_fl) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
                m_fl = 0; m_rsp = 1; m_data = m_pend; m_id = m_pid; m_err = 0;
            end
        end
        if (idle && (bus.req0_valid || bus.req1_valid)) begin
            if (w == 1) m_acc1 = 1; else m_acc0 = 1;
            m_ptr = (w == 0);
`ifdef ALU_ILLEGAL_FN_CHECK_EN
            bad = !tb_legal(fn);
`endif
            if (bad) begin
                m_rsp = 1; m_data = '0; m_err = 1; m_id = w[0];
            end else begin
                m_fn = fn; m_a = a; m_b = b; m_fl = 1; m_pid = w[0];
                m_wait = (fn == 6'b100010 || fn == 6'b110010) ? MC : 1;
                m_pend = alu_ref(fn, a, b);
            end
        end
    endtask

    // One clock: compare settled outputs, advance the model, wait for the next falling edge.
    task automatic cyc();
        #1;
        compare();
        step();
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input bit v, input logic [5:0] fn, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_fn = fn; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_fn = fn; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] fn_tab[8] = '{6'b100000, 6'b100001, 6'b101000, 6'b101001,
                                  6'b101010, 6'b100010, 6'b110010, 6'b110000};
        bit p[2];
        logic [5:0] pf[2];
        logic [DW-1:0] pa[2], pb[2];
        int k;
        m_reset();
        set_req(0, 1, 6'b100000, 1, 1);
        set_req(1, 0, 6'b100000, 0, 0);
        bus.rsp_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req0_ready", 64'(bus.req0_ready), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_alu_fn", 64'(bus.alu_fn), 64'(6'b100000));
        chk("rst_alu_a", 64'(bus.alu_a), 64'(0));
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
        set_req(0, 0, 6'b100000, 0, 0);
        @(negedge clk);
        rst_n = 1;

        // Contention: alternating grants over 4 pairs.
        set_req(0, 1, 6'b100001, 10, 3);
        set_req(1, 1, 6'b101000, 32'hF0, 32'h3C);
        bus.rsp_ready = 1;
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            cyc();
            if (bus.rsp_valid) begin
                chk("rr_id", 64'(bus.rsp_id), 64'(k % 2));
                chk("rr_data", 64'(bus.rsp_data), (k % 2) ? 64'h30 : 64'd7);
                k++;
            end
        end
        chk("rr_pairs", 64'(k), 64'(8));
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        cyc();

        // Single ADD: one-cycle latency.
        set_req(0, 1, 6'b100000, 5, 7);
        #1;
        chk("add_ready", 64'(bus.req0_ready), 64'(1));
        cyc();
        set_req(0, 0, 0, 0, 0);
        chk("add_lat0", 64'(bus.rsp_valid), 64'(0));
        cyc();
        chk("add_valid", 64'(bus.rsp_valid), 64'(1));
        chk("add_data", 64'(bus.rsp_data), 64'd12);
        chk("add_id", 64'(bus.rsp_id), 64'(0));
        cyc();

        // MUL: operands held, result after MC cycles.
        set_req(0, 1, 6'b100010, 6, 7);
        cyc();
        set_req(0, 0, 0, 0, 0);
        for (int j = 0; j <= 3; j++) begin
            chk("mul_valid", 64'(bus.rsp_valid), 64'(j == 3));
            chk("mul_fn_hold", 64'(bus.alu_fn), 64'(6'b100010));
            chk("mul_a_hold", 64'(bus.alu_a), 64'd6);
            chk("mul_b_hold", 64'(bus.alu_b), 64'd7);
            if (j < 3) cyc();
        end
        chk("mul_data", 64'(bus.rsp_data), 64'd42);
        cyc();

        // Backpressure with requester 1 waiting.
        bus.rsp_ready = 0;
        set_req(0, 1, 6'b100000, 1, 2);
        cyc();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 1, 6'b101010, 5, 3);
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(bus.rsp_valid), 64'(1));
            chk("bp_data", 64'(bus.rsp_data), 64'd3);
            chk("bp_id", 64'(bus.rsp_id), 64'(0));
            chk("bp_req1_ready", 64'(bus.req1_ready), 64'(0));
            cyc();
        end
        bus.rsp_ready = 1;
        #1;
        chk("bp_release_ready", 64'(bus.req1_ready), 64'(0));
        cyc();
        chk("bp_next_ready", 64'(bus.req1_ready), 64'(1));
        cyc();
        set_req(1, 0, 0, 0, 0);
        repeat (2) cyc();

        // Asynchronous reset in the middle of a multiply.
        set_req(0, 1, 6'b100010, 3, 4);
        cyc();
        set_req(0, 0, 0, 0, 0);
        cyc();
        rst_n = 0;
        #1;
        chk("mrst_busy", 64'(bus.busy), 64'(0));
        chk("mrst_alu_fn", 64'(bus.alu_fn), 64'(6'b100000));
        chk("mrst_alu_a", 64'(bus.alu_a), 64'(0));
        chk("mrst_rsp_data", 64'(bus.rsp_data), 64'(0));
        chk("mrst_rsp_id", 64'(bus.rsp_id), 64'(0));
        m_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("mrst_no_rsp", 64'(bus.rsp_valid), 64'(0));
        end
        set_req(0, 1, 6'b100000, 1, 1);
        set_req(1, 1, 6'b100000, 2, 2);
        #1;
        chk("mrst_ptr0_r0", 64'(bus.req0_ready), 64'(1));
        chk("mrst_ptr0_r1", 64'(bus.req1_ready), 64'(0));
        cyc();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (3) cyc();

        // Code outside the legal set.
        set_req(0, 1, 6'b111111, 9, 9);
        cyc();
        set_req(0, 0, 0, 0, 0);
`ifdef ALU_ILLEGAL_FN_CHECK_EN
        chk("ill_valid", 64'(bus.rsp_valid), 64'(1));
        chk("ill_err", 64'(bus.rsp_err), 64'(1));
        chk("ill_data", 64'(bus.rsp_data), 64'(0));
        chk("ill_alu_fn", 64'(bus.alu_fn), 64'(6'b100000));
`else
        chk("ill_lat0", 64'(bus.rsp_valid), 64'(0));
        chk("ill_alu_fn", 64'(bus.alu_fn), 64'(6'b111111));
        cyc();
        chk("ill_valid", 64'(bus.rsp_valid), 64'(1));
        chk("ill_err", 64'(bus.rsp_err), 64'(0));
        chk("ill_data", 64'(bus.rsp_data), 64'hFFFFFFFF);
`endif
        cyc();

        // Randomized traffic with random backpressure and abandoned requests.
        p[0] = 0; p[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < 2; r++) begin
                bit acc = r == 0 ? m_acc0 : m_acc1;
                bit dropped = 0;
                if (p[r] && acc) p[r] = 0;
                else if (p[r] && $urandom_range(7) == 0) begin p[r] = 0; dropped = 1; end
                if (!p[r] && !dropped && $urandom_range(1) == 1) begin
                    int idx = $urandom_range(8);
                    p[r] = 1;
                    pf[r] = idx == 8 ? 6'($urandom_range(63)) : fn_tab[idx];
                    pa[r] = $urandom;
                    pb[r] = $urandom;
                end
                set_req(r, p[r], pf[r], pa[r], pb[r]);
            end
            bus.rsp_ready = $urandom_range(3) != 0;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencer and arbiter that shares the single combinational ALU between two requesters: port 0 is the execute path and port 1 is the address/branch-target path.
- Accepts one operation at a time over a valid/ready handshake and drives the ALU's a, b and alufn inputs from registers.
- Holds those inputs stable for the required number of cycles, captures the result, and returns it with the requester ID over a valid/ready response channel.
- Multiply operations take multiple cycles; all other operations take one ALU cycle.

Parameters:
- MUL_CYCLES, default 3: number of cycles the ALU inputs are held for MUL/MULC before the result is captured. Must be >= 1.
- DW, default 32: operand and result width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_fn  in  6  requester 0 alufn code.
- req0_a  in  DW  requester 0 operand a.
- req0_b  in  DW  requester 0 operand b.
- req1_valid, req1_ready, req1_fn, req1_a, req1_b: same as requester 0, for requester 1.
- alu_a  out  DW  registered operand a to the ALU.
- alu_b  out  DW  registered operand b to the ALU.
- alu_fn  out  6  registered function code to the ALU.
- alu_y  in  DW  ALU result (combinational from alu_a, alu_b, alu_fn).
- rsp_valid  out  1  a result is available.
- rsp_ready  in  1  the consumer accepts the result.
- rsp_id  out  1  index of the requester that owns the result.
- rsp_data  out  DW  captured result.
- rsp_err  out  1  illegal alufn flag; tied to 0 unless the optional feature is compiled in.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - FSM in IDLE; round-robin pointer = 0; cycle counter = 0.
  - alu_a = 0, alu_b = 0, alu_fn = 6'b100000 (ADD, a legal code).
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0, busy = 0.
  - req0_ready and req1_ready = 0.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - req0_ready and req1_ready are combinational. At most one of them is high.
  - req_i_ready = req_i_valid AND grant_i.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester selected by the round-robin pointer is granted. The pointer then moves to the other index.
  - A single valid requester also sets the pointer to the other index.
  - On acceptance: latch fn, a and b into alu_fn, alu_a and alu_b; latch the ID; load the counter (MUL_CYCLES-1 for MUL 6'b100010 or MULC 6'b110010, otherwise 0); go to EXEC.
  - With no valid requester, the state and the ALU input registers are unchanged.
- EXEC:
  - alu_a, alu_b and alu_fn are held constant for the whole state.
  - If counter = 0: capture alu_y into rsp_data, set rsp_id, set rsp_valid = 1, go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - rsp_valid stays high, and rsp_data and rsp_id stay stable until rsp_ready = 1.
  - On the cycle rsp_ready = 1: clear rsp_valid and go to IDLE.
  - No new request is accepted in RESP. A new acceptance is possible on the next cycle, from IDLE.
- Latency from acceptance edge to rsp_valid high: 1 cycle for non-multiply operations, MUL_CYCLES cycles for multiply.
- Minimum issue interval: 3 cycles for non-multiply operations, MUL_CYCLES+2 for multiply.
- ALU inputs keep the last issued operation while in IDLE or RESP. They never float and never take a new code except on acceptance.
- A requester must hold valid, fn, a and b stable until it sees ready. Deasserting valid without ready is allowed; no grant occurs in that case.
- Asserting rst_n low mid-operation returns everything to the reset values. The in-flight operation and any pending response are dropped.
- Legal alufn set: 100000, 110000, 101000, 111000, 100100, 110100, 100110, 110110, 100101, 110101, 011000, 011111, 100010, 110010, 101001, 111001, 101100, 111100, 101101, 111101, 101110, 011001, 100001, 110001, 101010, 111010, 011011, 011101, 011110.

Optional Feature:
- Macro ALU_ILLEGAL_FN_CHECK_EN.
- Defined:
  - On acceptance of an fn outside the legal set, alu_fn is NOT updated (it keeps its previous value) and EXEC is skipped.
  - The FSM goes straight to RESP with rsp_data = 0, rsp_err = 1 and rsp_id set. Latency is 1 cycle.
  - rsp_err = 0 for all legal codes.
- Undefined:
  - Every fn is passed through to the ALU and handled as a non-multiply operation.
  - rsp_err is tied to 0.

Decomposition:
- Package alu_ctrl_pkg holds:
  - localparam constants for all 29 alufn codes (FN_ADD, FN_MUL, FN_MULC, ...);
  - function is_mul_fn(fn);
  - function is_legal_fn(fn);
  - FSM state typedef {IDLE, EXEC, RESP}.
- One sub-module, alu_rr_arb2: combinational 2-way grant from the two valid bits and the pointer, plus the pointer register. The pointer has clk and rst_n ports and updates on an accept-enable input.

Test Plan:
- Only req0 valid: fn=100000, a=5, b=7 -> req0_ready high in IDLE; rsp_valid 1 cycle after accept; rsp_data=12, rsp_id=0.
- Both valid after reset: req0 fn=100001 (a=10, b=3), req1 fn=101000 (a=0xF0, b=0x3C) -> req0 granted first with rsp_data=7; req1 granted next with rsp_data=0x30; pointer alternates over 4 back-to-back pairs.
- MUL with MUL_CYCLES=3: fn=100010, a=6, b=7 -> alu_fn, alu_a, alu_b constant for 3 EXEC cycles; rsp_data=42 exactly 3 cycles after accept.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_id held constant; req1_valid=1 throughout gets no ready until 1 cycle after rsp_ready=1.
- Reset mid-EXEC of a MUL: rst_n low for 1 cycle -> all outputs at reset values immediately (asynchronous); pointer=0; no rsp_valid afterwards.
- With ALU_ILLEGAL_FN_CHECK_EN: fn=111111 -> rsp_err=1, rsp_data=0, alu_fn unchanged. Without the macro: rsp_err=0 and the same op completes in 1 cycle.
